// File: rtl/mult_seq_if.sv
// Operand/result handshake bundle for the sequential multiplier.
// The slave modport is the multiplier. The master modport is the producer/consumer side.
interface mult_seq_if #(
  parameter int W = 8
);
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           tc;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] o;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output x, y, tc, in_valid, out_ready,
    input  in_ready, o, out_valid
  );

  modport slave (
    input  x, y, tc, in_valid, out_ready,
    output in_ready, o, out_valid
  );
endinterface

// File: rtl/mult_seq.sv
// Iterative W x W -> 2W multiplier that retires R multiplier bits per cycle.
// It supports unsigned or two's-complement operands, chosen per transaction.
module mult_seq #(
  parameter int W = 8,
  parameter int R = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  mult_seq_if.slave bus
);
  localparam int              STEPS = W / R;
  localparam int              CW    = $clog2(STEPS) + 1;
  localparam int              PW    = 2 * W;
  localparam logic [CW-1:0]   LAST  = CW'(STEPS - 1);

  generate
    if (W < 2 || (W % R) != 0 || !(R == 1 || R == 2 || R == 4)) begin : g_bad_cfg
      $error("mult_seq: illegal parameters (need W>=2, R in {1,2,4}, W%%R==0)");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_xr;
  logic [W-1:0]    r_yr;
  logic            r_tcr;
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_o;
  logic            r_out_valid;
  logic            r_run;

  logic            w_accept;
  logic [PW-1:0]   w_row [R];
  logic [PW-1:0]   w_cs_s;
  logic [PW-1:0]   w_cs_c;
  logic [PW-1:0]   w_cs_t;
  logic [PW-1:0]   w_sum;

  // r_run keeps in_ready low through reset and opens it on the first edge after release.
  assign bus.in_ready  = r_run & ((r_state == IDLE) | ((r_state == DONE) & bus.out_ready));
  assign w_accept      = bus.in_valid & bus.in_ready;
  assign bus.o         = r_o;
  assign bus.out_valid = r_out_valid;

  // The operands shift each cycle, so row gi always uses y bit gi against xr << gi.
  generate
    for (genvar gi = 0; gi < R; gi++) begin : g_row
      logic [PW-1:0] w_pp;
      assign w_pp = r_yr[gi] ? (r_xr << gi) : '0;
      if (gi == R - 1) begin : g_top
        // The sign row (y bit W-1) has negative weight in two's-complement mode.
        assign w_row[gi] = (r_tcr && (r_cnt == LAST)) ? (~w_pp + PW'(1)) : w_pp;
      end else begin : g_mid
        assign w_row[gi] = w_pp;
      end
    end
  endgenerate

  // Carry-save compression of acc plus R rows, then one carry-propagate add.
  always_comb begin
    w_cs_s = r_acc;
    w_cs_c = '0;
    w_cs_t = '0;
    for (int j = 0; j < R; j++) begin
      w_cs_t = w_cs_s ^ w_cs_c ^ w_row[j];
      w_cs_c = ((w_cs_s & w_cs_c) | (w_cs_s & w_row[j]) | (w_cs_c & w_row[j])) << 1;
      w_cs_s = w_cs_t;
    end
  end

  assign w_sum = w_cs_s + w_cs_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_xr        <= '0;
      r_yr        <= '0;
      r_tcr       <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_o         <= '0;
      r_out_valid <= 1'b0;
      r_run       <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_accept) begin
        r_xr        <= bus.tc ? {{W{bus.x[W-1]}}, bus.x} : {{W{1'b0}}, bus.x};
        r_yr        <= bus.y;
        r_tcr       <= bus.tc;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_out_valid <= 1'b0;
        r_state     <= BUSY;
      end else begin
        case (r_state)
          BUSY: begin
            r_acc <= w_sum;
            r_xr  <= r_xr << R;
            r_yr  <= r_yr >> R;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
              r_o         <= w_sum;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
          end
          DONE: begin
            if (bus.out_ready) begin
              r_out_valid <= 1'b0;
              r_state     <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq: three instances (8/2, 4/1, 16/4) driven with random traffic.
// Expected products come from a plain-arithmetic reference model.
module tb_mult_seq;
  logic clk;
  logic rst_n;

  mult_seq_if #(.W(8))  if8 ();
  mult_seq_if #(.W(4))  if4 ();
  mult_seq_if #(.W(16)) if16 ();

  mult_seq #(.W(8),  .R(2)) u8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  mult_seq #(.W(4),  .R(1)) u4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  mult_seq #(.W(16), .R(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  localparam int LAT = 4;  // W/R for every instance here

  typedef struct {
    logic [31:0] o;
    int          t;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   stim_done [3];
  logic pv [3];
  logic ptook [3];
  logic [31:0] po [3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input int w, input logic [15:0] xv, input logic [15:0] yv,
                                        input logic tcv);
    longint a;
    longint b;
    longint m;
    a = longint'(xv) & ((longint'(1) << w) - 1);
    b = longint'(yv) & ((longint'(1) << w) - 1);
    if (tcv && xv[w-1]) a = a - (longint'(1) << w);
    if (tcv && yv[w-1]) b = b - (longint'(1) << w);
    m = (longint'(1) << (2 * w)) - 1;
    return 32'((a * b) & m);
  endfunction

  function automatic int wid(input int k);
    case (k)
      0:       return 8;
      1:       return 4;
      default: return 16;
    endcase
  endfunction

  function automatic logic [31:0] get_o(input int k);
    case (k)
      0:       return 32'(if8.o);
      1:       return 32'(if4.o);
      default: return 32'(if16.o);
    endcase
  endfunction

  function automatic logic get_ov(input int k);
    case (k)
      0:       return if8.out_valid;
      1:       return if4.out_valid;
      default: return if16.out_valid;
    endcase
  endfunction

  function automatic logic get_ordy(input int k);
    case (k)
      0:       return if8.out_ready;
      1:       return if4.out_ready;
      default: return if16.out_ready;
    endcase
  endfunction

  function automatic logic get_ir(input int k);
    case (k)
      0:       return if8.in_ready;
      1:       return if4.in_ready;
      default: return if16.in_ready;
    endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t front(input int k);
    case (k)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic exp_t pop(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic push(input int k, input logic [31:0] ov, input int t);
    exp_t e;
    e.o = ov;
    e.t = t;
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic set_in(input int k, input logic v, input logic [15:0] xv, input logic [15:0] yv,
                        input logic tcv);
    case (k)
      0: begin if8.in_valid = v; if8.x = xv[7:0]; if8.y = yv[7:0]; if8.tc = tcv; end
      1: begin if4.in_valid = v; if4.x = xv[3:0]; if4.y = yv[3:0]; if4.tc = tcv; end
      default: begin if16.in_valid = v; if16.x = xv; if16.y = yv; if16.tc = tcv; end
    endcase
  endtask

  task automatic set_ordy(input int k, input logic v);
    case (k)
      0:       if8.out_ready = v;
      1:       if4.out_ready = v;
      default: if16.out_ready = v;
    endcase
  endtask

  // Call at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic drive(input int k, input logic [15:0] xv, input logic [15:0] yv, input logic tcv,
                       output int waited);
    bit done;
    done   = 1'b0;
    waited = 0;
    set_in(k, 1'b1, xv, yv, tcv);
    while (!done) begin
      @(negedge clk);
      if (rst_n && get_ir(k)) begin
        push(k, model(wid(k), xv, yv, tcv), cyc + 1 + LAT);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 500) begin
          chk("accept_timeout", 32'(waited), 32'(0));
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    set_in(k, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rnd_ready(input int k);
    while (!stim_done[k]) begin
      @(posedge clk);
      #1;
      set_ordy(k, $urandom_range(0, 3) != 0);
    end
    set_ordy(k, 1'b1);
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks hold/latency rules.
  initial begin : monitor
    logic        ov;
    logic        ordy;
    logic        ird;
    logic        fresh;
    logic [31:0] ob;
    exp_t        e;
    for (int k = 0; k < 3; k++) begin
      pv[k] = 1'b0; ptook[k] = 1'b0; po[k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!rst_n) begin
          pv[k]    = 1'b0;
          ptook[k] = 1'b0;
        end else begin
          ov   = get_ov(k);
          ordy = get_ordy(k);
          ird  = get_ir(k);
          ob   = get_o(k);
          if (pv[k] && !ptook[k]) begin
            chk("hold_valid", 32'(ov), 32'(1));
            chk("hold_o", ob, po[k]);
          end
          if (ov && !ordy) chk("bp_in_ready", 32'(ird), 32'(0));
          fresh = ov && !(pv[k] && !ptook[k]);
          if (fresh) begin
            chk("result_expected", 32'(qsize(k) > 0), 32'(1));
            if (qsize(k) > 0) begin
              e = front(k);
              chk("latency", 32'(cyc), 32'(e.t));
            end
          end
          if (ov && ordy && qsize(k) > 0) begin
            e = pop(k);
            $display("k=%0d result o=%h exp=%h", k, ob, e.o);
            chk("product", ob, e.o);
          end
          pv[k]    = ov;
          ptook[k] = ov && ordy;
          po[k]    = ob;
        end
      end
    end
  end

  logic [15:0] sx [3];
  logic [15:0] sy [3];
  logic        stc [3];
  logic [31:0] sexp [3];

  initial begin : main
    int          w;
    logic [31:0] hold;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_in(k, 1'b0, 16'h0, 16'h0, 1'b0);
      set_ordy(k, 1'b1);
      stim_done[k] = 1'b0;
    end
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("rst_o", get_o(k), 32'h0);
      chk("rst_valid", 32'(get_ov(k)), 32'(0));
      chk("rst_in_ready", 32'(get_ir(k)), 32'(0));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_reset", 32'(get_ir(0)), 32'(1));
    @(posedge clk);
    #1;

    // Unsigned 0xFF*0xFF with exact latency and a one-cycle valid pulse.
    drive(0, 16'h00FF, 16'h00FF, 1'b0, w);
    $display("accept x=ff y=ff tc=0");
    gap(3);
    chk("not_early", 32'(get_ov(0)), 32'(0));
    gap(1);
    chk("valid_at_lat", 32'(get_ov(0)), 32'(1));
    chk("ff_ff_u", get_o(0), 32'h0000FE01);
    gap(1);
    chk("valid_one_cycle", 32'(get_ov(0)), 32'(0));

    sx[0] = 16'h80; sy[0] = 16'h80; stc[0] = 1'b1; sexp[0] = 32'h4000;
    sx[1] = 16'hFF; sy[1] = 16'h01; stc[1] = 1'b1; sexp[1] = 32'hFFFF;
    sx[2] = 16'hFF; sy[2] = 16'h01; stc[2] = 1'b0; sexp[2] = 32'h00FF;
    for (int i = 0; i < 3; i++) begin
      drive(0, sx[i], sy[i], stc[i], w);
      $display("accept x=%h y=%h tc=%0d", sx[i][7:0], sy[i][7:0], stc[i]);
      gap(LAT);
      chk("directed_o", get_o(0), sexp[i]);
      gap(1);
    end

    // Backpressure: hold result for 5 cycles, then release with a same-cycle accept.
    set_ordy(0, 1'b0);
    drive(0, 16'h0A, 16'h0B, 1'b0, w);
    gap(LAT);
    chk("bp_valid", 32'(get_ov(0)), 32'(1));
    hold = get_o(0);
    chk("bp_o", hold, 32'h006E);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_o", get_o(0), hold);
      chk("bp_hold_v", 32'(get_ov(0)), 32'(1));
      chk("bp_hold_ir", 32'(get_ir(0)), 32'(0));
    end
    @(posedge clk);
    #1;
    set_ordy(0, 1'b1);
    drive(0, 16'h03, 16'h05, 1'b0, w);
    chk("bp_accept_same_cycle", 32'(w), 32'(0));
    gap(LAT);
    chk("bp_next_valid", 32'(get_ov(0)), 32'(1));
    chk("bp_next_o", get_o(0), 32'h000F);
    gap(1);

    // Reset during the second BUSY cycle.
    drive(0, 16'h12, 16'h34, 1'b0, w);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_o", get_o(0), 32'h0);
    chk("midrst_valid", 32'(get_ov(0)), 32'(0));
    chk("midrst_ir", 32'(get_ir(0)), 32'(0));
    q0.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    gap(6);
    chk("no_spurious_valid", 32'(get_ov(0)), 32'(0));
    drive(0, 16'h02, 16'h03, 1'b0, w);
    gap(LAT);
    chk("post_rst_o", get_o(0), 32'h0006);
    gap(1);

    // Random traffic on all three instances in parallel.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          drive(0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), w);
          gap($urandom_range(0, 2));
        end
        stim_done[0] = 1'b1;
      end
      begin
        for (int t = 0; t < 2; t++)
          for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
              drive(1, 16'(a), 16'(b), 1'(t), w);
              gap($urandom_range(0, 2));
            end
        stim_done[1] = 1'b1;
      end
      begin
        drive(2, 16'h8000, 16'h8000, 1'b1, w);
        for (int i = 0; i < 2500; i++) begin
          drive(2, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), w);
          gap($urandom_range(0, 1));
        end
        stim_done[2] = 1'b1;
      end
      rnd_ready(0);
      rnd_ready(1);
      rnd_ready(2);
    join

    for (int k = 0; k < 3; k++) begin
      int n;
      n = 0;
      while (qsize(k) > 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("drain", 32'(qsize(k)), 32'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
